iterative_shift_left: RTL and testbench
=======================================

// Module: iterative_shift_left
// PURPOSE
//  Multi-cycle logical left shifter (RV64 SLL/SLLI, optionally SLLW) for the execute stage.
//  Counterpart of the arithmetic right shifter. Trades area for latency by shifting at most
//  STEP bits per cycle. Uses a valid/ready handshake on both sides so the ALU can stall on it.
// PARAMETERS
//  XLEN   64  operand/result width (power of two, >=32)
//  STEP   8   max bits shifted per SHIFT cycle (power of two, 1..XLEN)
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  flush      in   1            synchronous kill of any in-flight op
//  in_valid   in   1            operand request valid
//  in_ready   out  1            shifter can accept a request
//  in_a       in   XLEN         value to shift
//  in_shamt   in   $clog2(XLEN) shift amount (upper bits ignored for word ops)
//  in_word    in   1            SLLW request (only honoured with SLL_WORD_EN)
//  out_valid  out  1            result valid
//  out_ready  in   1            consumer takes result
//  out_result out  XLEN         shifted value
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, out_result=0, internal counters 0.
//  - States: IDLE -> SHIFT -> DONE -> IDLE.
//  - in_ready = (state==IDLE). Accept on in_valid&&in_ready: latch acc=in_a, rem=in_shamt.
//    rem==0 -> DONE next cycle; else -> SHIFT.
//  - SHIFT, each cycle: k=min(rem,STEP); acc<=acc<<k (zero fill); rem<=rem-k;
//    rem-k==0 -> DONE. No wrap: bits shifted past MSB are lost.
//  - Latency accept->out_valid = 1 + ceil(shamt/STEP) cycles (shamt 0 -> 1 cycle).
//  - DONE: out_valid=1, out_result=acc, held stable until out_ready. On out_valid&&out_ready
//    -> IDLE; new request not accepted in that same cycle (in_ready low in DONE).
//  - out_result is 0 whenever out_valid=0.
//  - flush (any state) -> IDLE next edge, out_valid=0, result discarded; flush overrides
//    accept and handshake in the same cycle.
//  - Async rst mid-operation: immediate return to reset values, no output produced.
//  - in_a/in_shamt changes while not accepted are ignored; operands are captured only on accept.
// CONFIGURATION
//  SLL_WORD_EN defined: in_word=1 uses shamt[4:0] only; result = sext(acc[31:0]<<shamt)
//    to XLEN, sign bit = bit 31 of final shifted value; latency uses the 5-bit amount.
//  SLL_WORD_EN undefined: in_word ignored, always full-XLEN SLL with $clog2(XLEN)-bit shamt.
// STRUCTURE
//  Shared package riscv_shift_pkg: XLEN default constant, SHAMT_W=$clog2(XLEN),
//    shift_state_t enum {IDLE, SHIFT, DONE}.
//  Sub-module shift_left_step: combinational acc<<k, k in 0..STEP, zero fill; one instance.
// TESTING
//  1 a=64'h1, shamt=0 -> out_valid 1 cycle after accept, result 64'h1.
//  2 a=64'h1, shamt=63, STEP=8 -> result 64'h8000_0000_0000_0000 after 1+8 cycles.
//  3 a=64'hFFFF_FFFF_FFFF_FFFF, shamt=20 -> 64'hFFFF_FFFF_FFF0_0000; hold out_ready=0
//    5 cycles -> result stable, in_ready=0 throughout.
//  4 Accept a=64'h5, shamt=40; assert flush in 2nd SHIFT cycle -> IDLE next edge,
//    no out_valid; next request a=64'h3, shamt=1 -> 64'h6.
//  5 Assert rst during SHIFT -> in_ready=1, out_valid=0, out_result=0 immediately.
//  6 (SLL_WORD_EN) a=64'h0000_0000_0000_0001, shamt=31, in_word=1 ->
//    64'hFFFF_FFFF_8000_0000; without macro same stimulus -> 64'h0000_0000_8000_0000.

Source files
------------

// File: rtl/riscv_shift_pkg.sv
// ============================================================================
// riscv_shift_pkg : shared constants and state encoding for the shifters
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_shift_pkg;

   localparam int XLEN_DEF = 64;
   localparam int SHAMT_W  = $clog2(XLEN_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shift_state_t;

endpackage

`default_nettype wire

// File: rtl/shift_left_step.sv
// ============================================================================
// shift_left_step : combinational left shift by 0..STEP bits, zero fill
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_left_step #(
   parameter int XLEN = 64,
   parameter int STEP = 8,
   parameter int KW   = $clog2(STEP + 1)
) (
   input  logic [XLEN-1:0] acc,
   input  logic [KW-1:0]   k,
   output logic [XLEN-1:0] result
);

   assign result = acc << k;

endmodule

`default_nettype wire

// File: rtl/iterative_shift_left.sv
// ============================================================================
// iterative_shift_left : multi-cycle logical left shifter, STEP bits per cycle
// Optional SLLW support when SLL_WORD_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iterative_shift_left
   import riscv_shift_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int STEP = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_a,
   input  logic [$clog2(XLEN)-1:0]  in_shamt,
   input  logic                     in_word,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_result
);

   localparam int SW = $clog2(XLEN);
   localparam int KW = $clog2(STEP + 1);

   shift_state_t    state, state_nxt;
   logic [XLEN-1:0] acc, acc_nxt, step_result, final_result;
   logic [SW-1:0]   rem, rem_nxt, shamt_eff, rem_after;
   logic [KW-1:0]   step_k;
   logic            word_q, word_nxt;

`ifdef SLL_WORD_EN
   // Word ops only look at the low 5 bits of the amount.
   assign shamt_eff    = in_word ? SW'(in_shamt[4:0]) : in_shamt;
   assign word_nxt     = (state == IDLE && in_valid) ? in_word : word_q;
   assign final_result = word_q ? {{(XLEN-32){acc[31]}}, acc[31:0]} : acc;
`else
   logic unused_word;
   assign unused_word  = in_word;
   assign shamt_eff    = in_shamt;
   assign word_nxt     = 1'b0;
   assign final_result = acc;
`endif

   assign step_k    = (32'(rem) < 32'(STEP)) ? KW'(rem) : KW'(STEP);
   assign rem_after = rem - SW'(step_k);

   shift_left_step #(
      .XLEN (XLEN),
      .STEP (STEP),
      .KW   (KW)
   ) u_step (
      .acc    (acc),
      .k      (step_k),
      .result (step_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         rem    <= '0;
         word_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         rem    <= rem_nxt;
         word_q <= word_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      rem_nxt   = rem;
      case (state)
         IDLE: begin
            if (in_valid) begin
               acc_nxt   = in_a;
               rem_nxt   = shamt_eff;
               state_nxt = (shamt_eff == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            acc_nxt = step_result;
            rem_nxt = rem_after;
            if (rem_after == '0) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A flush kills whatever the FSM would otherwise do this cycle.
      if (flush) state_nxt = IDLE;
   end

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign out_result = (state == DONE) ? final_result : '0;

endmodule

`default_nettype wire

// File: tb/tb_iterative_shift_left.sv
// ============================================================================
// tb_iterative_shift_left : directed self-checking bench for iterative_shift_left
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iterative_shift_left;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_a = '0;
   logic [5:0]  in_shamt = '0;
   logic        in_word = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_result;

   int n_cmp = 0;
   int n_mis = 0;

   iterative_shift_left #(.XLEN(64), .STEP(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_shamt   (in_shamt),
      .in_word    (in_word),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Issue one request, check latency and result, then retire it.
   task automatic run_op(input string tag, input logic [63:0] a, input logic [5:0] sh,
                         input logic w, input logic [63:0] exp, input int exp_lat);
      int lat;
      @(negedge clk);
      in_a = a; in_shamt = sh; in_word = w; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = 64'hDEAD_BEEF_0BAD_F00D; in_shamt = 6'd17; in_word = 1'b0;
      wait_valid(lat);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " result"}, out_result, exp);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check({tag, " retire"}, {62'd0, out_valid, in_ready}, 64'd1);
   endtask

   initial begin
      int lat;
      #2;
      check("reset", {out_result[61:0], out_valid, in_ready}, 64'd1);
      @(negedge clk); rst = 1'b0;

      // 1, 2: zero shift and maximal shift
      run_op("t1", 64'h1, 6'd0, 1'b0, 64'h1, 1);
      run_op("t2", 64'h1, 6'd63, 1'b0, 64'h8000_0000_0000_0000, 9);
      run_op("t2b", 64'h0123_4567_89AB_CDEF, 6'd8, 1'b0, 64'h2345_6789_ABCD_EF00, 2);
      run_op("t2c", 64'hF000_0000_0000_0001, 6'd9, 1'b0, 64'h0000_0000_0000_0200, 3);

      // 3: hold result under back-pressure, no accept while DONE
      @(negedge clk);
      in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_shamt = 6'd20; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      wait_valid(lat);
      check("t3 latency", 64'(lat), 64'd4);
      in_valid = 1'b1; in_a = 64'h7; in_shamt = 6'd3;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("t3 hold result", out_result, 64'hFFFF_FFFF_FFF0_0000);
         check("t3 hold flags", {62'd0, out_valid, in_ready}, 64'd2);
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b0;
      check("t3 back to idle", {out_result[61:0], out_valid, in_ready}, 64'd1);

      // 4: flush in the second SHIFT cycle
      @(negedge clk);
      in_a = 64'h5; in_shamt = 6'd40; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check("t4 flushed", {out_result[61:0], out_valid, in_ready}, 64'd1);
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid) lat++;
      end
      check("t4 no output", 64'(lat), 64'd0);
      run_op("t4 next", 64'h3, 6'd1, 1'b0, 64'h6, 2);

      // 5: asynchronous reset in the middle of a shift
      @(negedge clk);
      in_a = 64'h1; in_shamt = 6'd63; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1; #1;
      check("t5 async reset", {out_result[61:0], out_valid, in_ready}, 64'd1);
      @(negedge clk); rst = 1'b0;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) lat++;
      end
      check("t5 no output", 64'(lat), 64'd0);

      // 6: word requests
`ifdef SLL_WORD_EN
      run_op("t6 word", 64'h1, 6'd31, 1'b1, 64'hFFFF_FFFF_8000_0000, 5);
      run_op("t6 word hi", 64'h1, 6'd33, 1'b1, 64'h2, 2);
      run_op("t6 word pos", 64'hFFFF_FFFF_0000_0003, 6'd4, 1'b1, 64'h30, 2);
`else
      run_op("t6 word", 64'h1, 6'd31, 1'b1, 64'h0000_0000_8000_0000, 5);
      run_op("t6 word hi", 64'h1, 6'd33, 1'b1, 64'h0000_0002_0000_0000, 6);
      run_op("t6 word pos", 64'hFFFF_FFFF_0000_0003, 6'd4, 1'b1, 64'hFFFF_FFF0_0000_0030, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
